// File: rtl/rob_multi_commit.sv
// Reorder buffer: in-order allocation, out-of-order writeback, in-order retire of up to COMMIT_W entries per cycle.
// Define ROB_PERF_CNT_EN to add the perf_commit_cnt / perf_flush_cnt retirement counters.
module rob_multi_commit #(
  parameter int DEPTH      = 8,
  parameter int COMMIT_W   = 2,
  parameter int WB_PORTS   = 2,
  parameter int DATA_W     = 32,
  parameter int PHY_ADDR_W = 6,
  parameter int PC_W       = 32,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           alloc_en,
  input  logic                           alloc_has_dest,
  input  logic [PHY_ADDR_W-1:0]          alloc_dest,
  output logic [AW-1:0]                  rob_tail_ptr,
  output logic                           rob_full,
  output logic                           rob_empty,
  output logic [AW:0]                    rob_count,
  input  logic [WB_PORTS-1:0]            wb_en,
  input  logic [WB_PORTS*AW-1:0]         wb_rob_addr,
  input  logic [WB_PORTS*DATA_W-1:0]     wb_value,
  input  logic [WB_PORTS-1:0]            wb_mispredict,
  input  logic [WB_PORTS*PC_W-1:0]       wb_target,
  output logic [COMMIT_W-1:0]            phy_rf_wr_en,
  output logic [COMMIT_W*PHY_ADDR_W-1:0] phy_rf_wr_addr,
  output logic [COMMIT_W*DATA_W-1:0]     phy_rf_wr_data,
  output logic [COMMIT_W-1:0]            busy_table_wr_en,
  output logic [COMMIT_W*PHY_ADDR_W-1:0] busy_table_wr_addr,
  output logic                           mispredicted_branch,
  output logic [PC_W-1:0]                pc_to_jump
`ifdef ROB_PERF_CNT_EN
  ,
  output logic [31:0]                    perf_commit_cnt,
  output logic [31:0]                    perf_flush_cnt
`endif
);

  logic [AW:0]             head_q, head_d, tail_q, tail_d;
  logic [DEPTH-1:0]        valid_q, valid_d, done_q, done_d, mis_q, mis_d;
  logic [DEPTH-1:0]        has_dest_q, has_dest_d;
  logic [PHY_ADDR_W-1:0]   dest_q   [DEPTH];
  logic [PHY_ADDR_W-1:0]   dest_d   [DEPTH];
  logic [DATA_W-1:0]       value_q  [DEPTH];
  logic [DATA_W-1:0]       value_d  [DEPTH];
  logic [PC_W-1:0]         target_q [DEPTH];
  logic [PC_W-1:0]         target_d [DEPTH];

  logic                    full, empty;
  logic [DEPTH-1:0]        fire_mask;
  logic [AW:0]             commit_cnt;
  logic                    flush;
  logic [PC_W-1:0]         flush_target;
  logic                    chain;
  logic [AW-1:0]           slot_idx;
  logic [AW-1:0]           wb_idx;
  logic [AW-1:0]           tail_idx;

  assign full         = (head_q[AW-1:0] == tail_q[AW-1:0]) && (head_q[AW] != tail_q[AW]);
  assign empty        = (head_q == tail_q);
  assign rob_full     = full;
  assign rob_empty    = empty;
  assign rob_count    = tail_q - head_q;
  assign rob_tail_ptr = tail_q[AW-1:0];
  assign tail_idx     = tail_q[AW-1:0];

  // Retire scan: a slot fires only behind an unbroken run of completed, non-mispredicted slots.
  always_comb begin
    fire_mask          = '0;
    commit_cnt         = '0;
    flush              = 1'b0;
    flush_target       = '0;
    chain              = 1'b1;
    slot_idx           = '0;
    phy_rf_wr_en       = '0;
    phy_rf_wr_addr     = '0;
    phy_rf_wr_data     = '0;
    busy_table_wr_en   = '0;
    busy_table_wr_addr = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      slot_idx = head_q[AW-1:0] + AW'(k);
      if (chain && valid_q[slot_idx] && done_q[slot_idx]) begin
        fire_mask[slot_idx]                              = 1'b1;
        commit_cnt                                       = commit_cnt + (AW+1)'(1);
        phy_rf_wr_en[k]                                  = has_dest_q[slot_idx];
        busy_table_wr_en[k]                              = has_dest_q[slot_idx];
        phy_rf_wr_addr[k*PHY_ADDR_W +: PHY_ADDR_W]       = dest_q[slot_idx];
        busy_table_wr_addr[k*PHY_ADDR_W +: PHY_ADDR_W]   = dest_q[slot_idx];
        phy_rf_wr_data[k*DATA_W +: DATA_W]               = value_q[slot_idx];
        if (mis_q[slot_idx]) begin
          flush        = 1'b1;
          flush_target = target_q[slot_idx];
          chain        = 1'b0;
        end
      end else begin
        chain = 1'b0;
      end
    end
  end

  assign mispredicted_branch = flush;
  assign pc_to_jump          = flush_target;

  always_comb begin
    head_d     = head_q + commit_cnt;
    tail_d     = tail_q;
    valid_d    = valid_q;
    done_d     = done_q;
    mis_d      = mis_q;
    has_dest_d = has_dest_q;
    dest_d     = dest_q;
    value_d    = value_q;
    target_d   = target_q;
    wb_idx     = '0;
    if (flush) begin
      // The flush squashes everything younger than the branch, so the ROB drains to empty.
      valid_d = '0;
      done_d  = '0;
      mis_d   = '0;
      tail_d  = head_d;
    end else begin
      for (int p = 0; p < WB_PORTS; p++) begin
        wb_idx = wb_rob_addr[p*AW +: AW];
        if (wb_en[p] && valid_q[wb_idx]) begin
          done_d[wb_idx]   = 1'b1;
          mis_d[wb_idx]    = wb_mispredict[p];
          value_d[wb_idx]  = wb_value[p*DATA_W +: DATA_W];
          target_d[wb_idx] = wb_target[p*PC_W +: PC_W];
        end
      end
      valid_d = valid_d & ~fire_mask;
      done_d  = done_d & ~fire_mask;
      mis_d   = mis_d & ~fire_mask;
      if (alloc_en && !full) begin
        valid_d[tail_idx]    = 1'b1;
        done_d[tail_idx]     = 1'b0;
        mis_d[tail_idx]      = 1'b0;
        has_dest_d[tail_idx] = alloc_has_dest;
        dest_d[tail_idx]     = alloc_dest;
        tail_d               = tail_q + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      valid_q    <= '0;
      done_q     <= '0;
      mis_q      <= '0;
      has_dest_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      mis_q      <= mis_d;
      has_dest_q <= has_dest_d;
    end
  end

  // Payload storage is qualified by the valid/done bits, so it needs no reset.
  always_ff @(posedge clk) begin
    dest_q   <= dest_d;
    value_q  <= value_d;
    target_q <= target_d;
  end

`ifdef ROB_PERF_CNT_EN
  logic [31:0] perf_commit_cnt_q, perf_commit_cnt_d;
  logic [31:0] perf_flush_cnt_q, perf_flush_cnt_d;

  always_comb begin
    perf_commit_cnt_d = perf_commit_cnt_q + 32'(commit_cnt);
    perf_flush_cnt_d  = perf_flush_cnt_q + 32'(flush);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_commit_cnt_q <= '0;
      perf_flush_cnt_q  <= '0;
    end else begin
      perf_commit_cnt_q <= perf_commit_cnt_d;
      perf_flush_cnt_q  <= perf_flush_cnt_d;
    end
  end

  assign perf_commit_cnt = perf_commit_cnt_q;
  assign perf_flush_cnt  = perf_flush_cnt_q;
`endif

endmodule

// File: doc/rob_multi_commit.md
Name: rob_multi_commit

Overview:
- Parametrised reorder buffer for the Qu back end; successor to the fixed 4-entry, single-retire ROB.
- Allocates entries in program order at dispatch and accepts out-of-order results from WB_PORTS writeback ports.
- Retires up to COMMIT_W completed entries per cycle, in order, to the physical register file and busy table.
- Raises a flush with a redirect PC when a retiring branch is marked mispredicted.

Parameters:
- DEPTH, 8, number of entries; power of two, >= 2. AW = $clog2(DEPTH).
- COMMIT_W, 2, maximum retirements per cycle; 1 <= COMMIT_W <= DEPTH.
- WB_PORTS, 2, number of result writeback ports.
- DATA_W, 32, result width.
- PHY_ADDR_W, 6, physical register address width.
- PC_W, 32, program counter width.

Ports:
- clk in 1: clock, rising edge.
- rst in 1: synchronous, active-high reset.
- alloc_en in 1: allocate one entry this cycle.
- alloc_has_dest in 1: entry writes a register.
- alloc_dest in PHY_ADDR_W: destination physical register.
- rob_tail_ptr out AW: index the next allocation receives.
- rob_full out 1: no free entry.
- rob_empty out 1: no valid entry.
- rob_count out AW+1: number of valid entries.
- wb_en in WB_PORTS: per-port result valid.
- wb_rob_addr in WB_PORTS*AW: per-port target entry.
- wb_value in WB_PORTS*DATA_W: per-port result.
- wb_mispredict in WB_PORTS: per-port branch mispredicted.
- wb_target in WB_PORTS*PC_W: per-port redirect PC.
- phy_rf_wr_en out COMMIT_W: per-slot register write.
- phy_rf_wr_addr out COMMIT_W*PHY_ADDR_W: per-slot write address.
- phy_rf_wr_data out COMMIT_W*DATA_W: per-slot write data.
- busy_table_wr_en out COMMIT_W: per-slot busy clear; data implicitly 0.
- busy_table_wr_addr out COMMIT_W*PHY_ADDR_W: per-slot busy address.
- mispredicted_branch out 1: flush request.
- pc_to_jump out PC_W: redirect PC, valid while mispredicted_branch = 1.

Behaviour:
Pointers and flags
- head and tail are AW+1 bits, including a wrap bit.
- rob_full when indices are equal and wrap bits differ; rob_empty when both are equal.
- rob_count = tail - head, taken modulo 2^(AW+1).

Reset
- Pointers = 0 and all entry valid/done/mispredict bits = 0.
- Resulting outputs: rob_empty = 1, rob_full = 0, rob_count = 0, rob_tail_ptr = 0.
- All wr_en bits = 0, mispredicted_branch = 0, pc_to_jump = 0, all data/address outputs = 0.
- Reset mid-operation discards all entries; no commit occurs on that edge.

Allocation
- On an edge with alloc_en = 1 and rob_full = 0 (registered state): entry[tail] is written with valid = 1, done = 0, mispredict = 0 and the dest fields, then tail increments.
- alloc_en while full is ignored.
- alloc_en in a cycle with mispredicted_branch = 1 is ignored.

Writeback
- On an edge, for each port with wb_en = 1 and entry[wb_rob_addr].valid = 1: set done, store value, mispredict and target.
- A write to an invalid entry is ignored.
- If two ports hit the same entry, the highest port index wins.

Commit
- Commit is combinational from registered state.
- Scan slots k = 0..COMMIT_W-1 at index head+k. Slot k fires only if:
  - it is valid and done,
  - all earlier slots fired,
  - no earlier slot was mispredicted.
- Per fired slot: phy_rf_wr_en[k] = busy_table_wr_en[k] = has_dest, with address = dest and data = value.
- At the next edge, head advances by the number of fired slots and those entries are cleared.
- Latency: writeback captured at edge N → commit ports asserted in the cycle after edge N → head advances at edge N+1.
- A commit and an allocation in the same cycle are both taken. rob_full and rob_count reflect post-edge state.

Flush
- If a fired slot is mispredicted: mispredicted_branch = 1 and pc_to_jump = its target, in the same cycle.
- Younger slots do not fire.
- At the next edge, all entries are invalidated and tail is set to the post-commit head, so the ROB is empty.
- Writebacks and allocations on that edge are dropped.

Optional Feature:
- Macro ROB_PERF_CNT_EN.
- When defined, adds outputs perf_commit_cnt (32 bits, total retired instructions) and perf_flush_cnt (32 bits, total flushes).
- Both counters wrap, reset to 0, and update at the same edge as head advance.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- All scenarios use DEPTH = 4, COMMIT_W = 2, WB_PORTS = 2.
- Reset held for 5 cycles → rob_empty = 1, rob_count = 0, rob_tail_ptr = 0, all wr_en = 0, mispredicted_branch = 0.
- Allocate dests 4, 5, 6, 7 on consecutive cycles → rob_tail_ptr reads 0, 1, 2, 3; rob_full = 1 after the 4th. A 5th alloc_en is ignored and rob_count stays 4.
- Write back entry 1 (value 22), then entry 0 (value 11) a cycle later:
  - no commit after the first writeback;
  - after the second: phy_rf_wr_en = 2'b11, addresses 4 and 5, data 11 and 22;
  - then rob_count = 2.
- Same-cycle writebacks to entries 2 and 3 (values 31, 32) on ports 0 and 1 → next cycle both commit with addresses 6 and 7. Also drive both ports to entry 2 with values 31 and 99 → stored value is 99.
- Four entries allocated; entry 0 done; entry 1 written back with mispredict and target 0x100 → entries 0 and 1 commit, mispredicted_branch = 1, pc_to_jump = 0x100. Next cycle rob_empty = 1, and a writeback to entry 2 is ignored.
- Six allocate/complete pairs with has_dest = 0 on the 3rd → rob_tail_ptr wraps 0, 1, 2, 3, 0, 1; commits are in order; no RF or busy write for the 3rd. rst asserted mid-sequence → empty on the next cycle.
